// File: rtl/ahb2apb_pkg.sv
// rtl/ahb2apb_pkg.sv - shared types, AHB encodings and helpers for the multi-slave AHB-to-APB bridge
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] strb_gen(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb2apb_decoder.sv
// rtl/ahb2apb_decoder.sv - maps the address window field onto a one-hot APB select, slave index and hit flag
module ahb2apb_decoder
  import ahb2apb_pkg::*;
#(
  parameter int ADDRWIDTH = 16,
  parameter int NUM_SLV   = 4,
  parameter int SLV_AW    = 12
) (
  input  logic [ADDRWIDTH-SLV_AW-1:0]     win_i,
  output logic [NUM_SLV-1:0]              sel_o,
  output logic [idx_width(NUM_SLV)-1:0]   idx_o,
  output logic                            in_range_o
);

  localparam int IW = idx_width(NUM_SLV);

  logic          hit;
  logic [IW-1:0] idx;

  // The whole field above the window is compared, so addresses beyond the last slave miss
  always_comb begin
    hit = 1'b1;
    idx = '0;
    if (NUM_SLV > 1) begin
      hit = int'(win_i) < NUM_SLV;
      idx = win_i[IW-1:0];
    end
    sel_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = hit && (idx == IW'(i));
    end
    idx_o      = idx;
    in_range_o = hit;
  end

endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// rtl/ahb2apb_bridge_mp.sv - AHB-Lite slave to multi-slave APB3 master bridge, PCLKEN-paced, HCLK domain only
// Optional APB4_EN adds PPROT/PSTRB outputs (DATAWIDTH must then be 32).
module ahb2apb_bridge_mp
  import ahb2apb_pkg::*;
#(
  parameter int ADDRWIDTH      = 16,
  parameter int DATAWIDTH      = 32,
  parameter int NUM_SLV        = 4,
  parameter int SLV_AW         = 12,
  parameter int REGISTER_RDATA = 1
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [ADDRWIDTH-1:0]         HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [3:0]                   HPROT,
  input  logic [DATAWIDTH-1:0]         HWDATA,
  input  logic                         HREADY,
  output logic                         HREADYOUT,
  output logic [DATAWIDTH-1:0]         HRDATA,
  output logic                         HRESP,
  input  logic                         PCLKEN,
  output logic [NUM_SLV-1:0]           PSEL,
  output logic                         PENABLE,
  output logic [ADDRWIDTH-1:0]         PADDR,
  output logic                         PWRITE,
  output logic [DATAWIDTH-1:0]         PWDATA,
  input  logic [NUM_SLV*DATAWIDTH-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]           PREADY,
  input  logic [NUM_SLV-1:0]           PSLVERR,
  output logic                         APBACTIVE
`ifdef APB4_EN
  ,
  output logic [2:0]                   PPROT,
  output logic [3:0]                   PSTRB
`endif
);

  localparam int IW = idx_width(NUM_SLV);

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-3:0]   addr_q;
  logic                   write_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_SLV-1:0]     sel_q;
  logic                   in_range_q;
  logic [ADDRWIDTH-1:0]   paddr_q;
  logic                   pwrite_q;
  logic [DATAWIDTH-1:0]   pwdata_q;
  logic [DATAWIDTH-1:0]   rdata_q;

  logic [NUM_SLV-1:0]     dec_sel;
  logic [IW-1:0]          dec_idx;
  logic                   dec_in_range;
  logic [DATAWIDTH-1:0]   prdata_sel;
  logic                   pready_sel;
  logic                   pslverr_sel;
  logic                   apb_done;
  logic                   hready_int;
  logic                   hresp_int;
  logic                   take;

  ahb2apb_decoder #(
    .ADDRWIDTH (ADDRWIDTH),
    .NUM_SLV   (NUM_SLV),
    .SLV_AW    (SLV_AW)
  ) u_decoder (
    .win_i      (HADDR[ADDRWIDTH-1:SLV_AW]),
    .sel_o      (dec_sel),
    .idx_o      (dec_idx),
    .in_range_o (dec_in_range)
  );

  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IW'(i)) begin
        prdata_sel  = PRDATA[i*DATAWIDTH +: DATAWIDTH];
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
      end
    end
  end

  assign apb_done = (state_q == ST_ACCESS) && PCLKEN && pready_sel;

  always_comb begin
    state_d    = state_q;
    hready_int = 1'b1;
    hresp_int  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: state_d = ST_IDLE;
      ST_ERR2: begin
        hresp_int = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_PEND: begin
        hready_int = 1'b0;
        if (!in_range_q)  state_d = ST_ERR1;
        else if (PCLKEN)  state_d = ST_SETUP;
      end
      ST_SETUP: begin
        hready_int = 1'b0;
        if (PCLKEN) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        hready_int = 1'b0;
        if (apb_done) begin
          if (pslverr_sel) begin
            state_d = ST_ERR1;
          end else if (REGISTER_RDATA != 0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_IDLE;
            hready_int = 1'b1;
          end
        end
      end
      ST_ERR1: begin
        hready_int = 1'b0;
        hresp_int  = 1'b1;
        state_d    = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new address phase is taken in any cycle this slave reports ready
    if (HSEL && HTRANS[1] && HREADY && hready_int) state_d = ST_PEND;
  end

  assign take = HSEL & HTRANS[1] & HREADY & hready_int;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      sel_q      <= '0;
      in_range_q <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q     <= HADDR[ADDRWIDTH-1:2];
        write_q    <= HWRITE;
        idx_q      <= dec_idx;
        sel_q      <= dec_sel;
        in_range_q <= dec_in_range;
      end
      // APB address/data are loaded on the PEND->SETUP edge so they only move on PCLKEN edges
      if (state_q == ST_PEND && in_range_q && PCLKEN) begin
        paddr_q  <= {addr_q, 2'b00};
        pwrite_q <= write_q;
        if (write_q) pwdata_q <= HWDATA;
      end
      if (REGISTER_RDATA != 0 && apb_done && !pslverr_sel) rdata_q <= prdata_sel;
    end
  end

`ifdef APB4_EN
  logic [2:0] pprot_q;
  logic [3:0] pstrb_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pprot_q <= '0;
      pstrb_q <= '0;
    end else if (take) begin
      pprot_q <= {~HPROT[0], 1'b0, HPROT[1]};
      pstrb_q <= HWRITE ? strb_gen(HSIZE, HADDR[1:0]) : 4'b0000;
    end
  end

  assign PPROT = pprot_q;
  assign PSTRB = pstrb_q;

  logic unused_ok;
  assign unused_ok = ^{HPROT[3:2], HTRANS[0]};
`else
  logic unused_ok;
  assign unused_ok = ^{HPROT, HSIZE, HADDR[1:0], HTRANS[0]};
`endif

  assign HREADYOUT = hready_int;
  assign HRESP     = hresp_int;
  assign HRDATA    = (REGISTER_RDATA == 0 && state_q == ST_ACCESS) ? prdata_sel : rdata_q;
  assign PSEL      = (state_q == ST_SETUP || state_q == ST_ACCESS) ? sel_q : '0;
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign APBACTIVE = (state_q == ST_PEND) || (state_q == ST_SETUP) || (state_q == ST_ACCESS);

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// tb/tb_ahb2apb_bridge_mp.sv - directed scoreboard bench for ahb2apb_bridge_mp (default build, APB4_EN optional)
module tb_ahb2apb_bridge_mp;
  import ahb2apb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 4;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             HSEL = 1'b0;
  logic [AW-1:0]    HADDR = '0;
  logic [1:0]       HTRANS = HTRANS_IDLE;
  logic             HWRITE = 1'b0;
  logic [2:0]       HSIZE = HSIZE_WORD;
  logic [3:0]       HPROT = 4'b0011;
  logic [DW-1:0]    HWDATA = '0;
  logic             HREADY = 1'b1;
  logic             HREADYOUT;
  logic [DW-1:0]    HRDATA;
  logic             HRESP;
  logic             PCLKEN = 1'b1;
  logic [NS-1:0]    PSEL;
  logic             PENABLE;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [NS*DW-1:0] PRDATA = '0;
  logic [NS-1:0]    PREADY = '0;
  logic [NS-1:0]    PSLVERR = '0;
  logic             APBACTIVE;
`ifdef APB4_EN
  logic [2:0]       PPROT;
  logic [3:0]       PSTRB;
`endif

  ahb2apb_bridge_mp dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PCLKEN(PCLKEN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .APBACTIVE(APBACTIVE)
`ifdef APB4_EN
    , .PPROT(PPROT), .PSTRB(PSTRB)
`endif
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] slv_data [NS];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        div3 = 1'b0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; when PCLKEN was low at the edge the APB outputs must not have moved
  task automatic step();
    logic          pe_prev, rst_prev;
    logic [52:0]   apb_prev;
    pe_prev  = PCLKEN;
    rst_prev = HRESETn;
    apb_prev = {PSEL, PENABLE, PADDR, PWDATA};
    @(posedge HCLK);
    #1;
    cyc++;
    if (div3 && !pe_prev && rst_prev) check("apb_hold_no_pclken", {PSEL, PENABLE, PADDR, PWDATA}, apb_prev);
    PCLKEN = div3 ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic ahb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                          input int stall, input logic exp_err, output int waits, output int pen,
                          output logic [NS-1:0] psel_seen, output int act);
    exp_t e;
    int   acc, guard, idx;
    logic err1_seen;
    idx       = int'(addr[AW-1:12]);
    e.is_read = !wr;
    e.err     = exp_err;
    e.data    = (idx < NS) ? slv_data[idx] : 32'h0;
    sb_q.push_back(e);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr;
    step();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wdata;
    waits = 0; pen = 0; psel_seen = '0; act = 0; acc = 0; guard = 0; err1_seen = 1'b0;
    while (!HREADYOUT && guard < 60) begin
      waits++; guard++;
      psel_seen |= PSEL;
      if (PENABLE) begin pen++; acc++; end
      if (APBACTIVE) act++;
      if (HRESP) err1_seen = 1'b1;
      PREADY = (PENABLE && acc > stall) ? '1 : '0;
      step();
    end
    PREADY = '0;
    if (guard >= 60) check("xfer_timeout", HREADYOUT, 1'b1);
    e = sb_q.pop_front();
    check("hresp_final", HRESP, e.err);
    check("hresp_with_wait", err1_seen, e.err);
    if (e.is_read && !e.err) check("hrdata", HRDATA, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            w, p, a, guard;
    logic [NS-1:0] ps;

    slv_data[0] = 32'h1111_0000;
    slv_data[1] = 32'h2222_0001;
    slv_data[2] = 32'hA5A5_0001;
    slv_data[3] = 32'h4444_0003;
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = slv_data[i];

    step(); step(); step();
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_hresp", HRESP, 1'b0);
    check("rst_psel", PSEL, 4'b0000);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, 16'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_apbactive", APBACTIVE, 1'b0);
    HRESETn = 1'b1;
    step();

    // IDLE and BUSY transfers are answered OKAY with no wait state
    HSEL = 1'b1; HTRANS = HTRANS_IDLE; HADDR = 16'h2000;
    step();
    check("idle_hreadyout", HREADYOUT, 1'b1);
    check("idle_apbactive", APBACTIVE, 1'b0);
    HTRANS = HTRANS_BUSY;
    step();
    check("busy_hreadyout", HREADYOUT, 1'b1);
    check("busy_hresp", HRESP, 1'b0);
    HSEL = 1'b0;

    ahb_xfer(16'h2004, 1'b0, 32'h0, 0, 1'b0, w, p, ps, a);
    check("rd2_waits", w, 3);
    check("rd2_psel", ps, 4'b0100);
    check("rd2_penable_cycles", p, 1);
    check("rd2_apbactive_cycles", a, 3);
    check("rd2_paddr", PADDR, 16'h2004);
    step();
    check("rd2_apbactive_after", APBACTIVE, 1'b0);

    ahb_xfer(16'h1010, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, w, p, ps, a);
    check("wr1_penable_cycles", p, 4);
    check("wr1_waits", w, 6);
    check("wr1_psel", ps, 4'b0010);
    check("wr1_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("wr1_paddr", PADDR, 16'h1010);
    check("wr1_pwrite", PWRITE, 1'b1);
    check("wr1_psel_after", PSEL, 4'b0000);

    PSLVERR = 4'b1000;
    ahb_xfer(16'h3000, 1'b0, 32'h0, 0, 1'b1, w, p, ps, a);
    check("slverr_waits", w, 4);
    check("slverr_psel", ps, 4'b1000);
    PSLVERR = '0;
    step();
    check("slverr_recover_hresp", HRESP, 1'b0);

    ahb_xfer(16'h5000, 1'b0, 32'h0, 0, 1'b1, w, p, ps, a);
    check("miss_psel", ps, 4'b0000);
    check("miss_waits", w, 2);
    check("miss_penable_cycles", p, 0);

    // PCLKEN 1-of-3 with a write immediately followed by a read
    div3 = 1'b1;
    ahb_xfer(16'h0008, 1'b1, 32'h1234_5678, 1, 1'b0, w, p, ps, a);
    check("div3_wr_psel", ps, 4'b0001);
    check("div3_wr_pwdata", PWDATA, 32'h1234_5678);
    ahb_xfer(16'h1004, 1'b0, 32'h0, 0, 1'b0, w, p, ps, a);
    check("div3_rd_psel", ps, 4'b0010);
    check("div3_rd_paddr", PADDR, 16'h1004);
    check("div3_rd_pwrite", PWRITE, 1'b0);
    div3 = 1'b0;
    PCLKEN = 1'b1;
    step();

    // Reset while a slave holds the bridge in ACCESS
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 16'h0000; HWRITE = 1'b0;
    step();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    PREADY = '0;
    guard = 0;
    while (!PENABLE && guard < 10) begin guard++; step(); end
    check("rst_mid_reached_access", PENABLE, 1'b1);
    HRESETn = 1'b0;
    step();
    check("rst_mid_psel", PSEL, 4'b0000);
    check("rst_mid_penable", PENABLE, 1'b0);
    check("rst_mid_hreadyout", HREADYOUT, 1'b1);
    check("rst_mid_apbactive", APBACTIVE, 1'b0);
    check("rst_mid_paddr", PADDR, 16'h0);
    check("rst_mid_pwdata", PWDATA, 32'h0);
    HRESETn = 1'b1;
    step();

    ahb_xfer(16'h0000, 1'b0, 32'h0, 0, 1'b0, w, p, ps, a);
    check("post_rst_waits", w, 3);
    check("post_rst_psel", ps, 4'b0001);

`ifdef APB4_EN
    HSIZE = HSIZE_HALF;
    ahb_xfer(16'h0002, 1'b1, 32'hCAFE_0000, 0, 1'b0, w, p, ps, a);
    check("apb4_pstrb_half_hi", PSTRB, 4'b1100);
    check("apb4_pprot", PPROT, 3'b001);
    HSIZE = HSIZE_WORD;
    ahb_xfer(16'h2000, 1'b0, 32'h0, 0, 1'b0, w, p, ps, a);
    check("apb4_pstrb_read", PSTRB, 4'b0000);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
